// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: 1-to-N valid/ready stream demultiplexer.
// Each input beat goes to the output channel named by s_sel. Every channel
// owns a one-entry registered slice, so a stalled consumer only blocks beats
// addressed to that consumer. Beats with s_sel >= N are accepted, dropped and
// reported by a one-cycle err_sel pulse.
// Optional feature: define DEMUX_CNT_EN to add per-channel saturating 16-bit
// delivered-beat counters on the cnt port.
module stream_demux_1ton #(
  parameter int unsigned width = 32,
  parameter int unsigned N     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [width-1:0]       s_data,
  input  logic [$clog2(N)-1:0]   s_sel,
  output logic [N-1:0]           m_valid,
  input  logic [N-1:0]           m_ready,
  output logic [width-1:0]       m_data [N],
  output logic                   err_sel
`ifdef DEMUX_CNT_EN
  ,
  output logic [15:0]            cnt [N]
`endif
);

  localparam int unsigned SEL_W = $clog2(N);
  localparam int unsigned CNT_W = 16;

  logic [N-1:0]     v_q;
  logic [width-1:0] r_q [N];
  logic             err_q;

  logic [N-1:0]     hit_c;
  logic [N-1:0]     load_c;
  logic [N-1:0]     drain_c;
  logic             in_range_c;
  logic             accept_c;

  // Select range check; only a real comparison when N is not a power of two.
  if ((1 << SEL_W) == N) begin : g_pow2
    assign in_range_c = 1'b1;
  end else begin : g_npow2
    assign in_range_c = (32'(s_sel) < N);
  end

  // One-hot decode of the destination channel.
  always_comb begin
    hit_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hit_c[i] = (s_sel == SEL_W'(i));
    end
  end

  // Ready: dropped beats always pass; otherwise the target slice must be free
  // or draining this cycle.
  assign s_ready  = !in_range_c || (|(hit_c & (~v_q | m_ready)));
  assign accept_c = s_valid && s_ready;
  assign load_c   = hit_c & {N{accept_c && in_range_c}};
  assign drain_c  = v_q & m_ready;

  // Per-channel slices: a load wins over a drain so one beat per cycle flows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (load_c[i]) begin
          v_q[i] <= 1'b1;
          r_q[i] <= s_data;
        end else if (drain_c[i]) begin
          v_q[i] <= 1'b0;
        end
      end
    end
  end

  // Out-of-range drop indication, registered for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept_c && !in_range_c;
    end
  end

  assign m_valid = v_q;
  assign m_data  = r_q;
  assign err_sel = err_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [N];

  // Delivered-beat counters, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (drain_c[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt = cnt_q;
`endif

endmodule
